// File: rtl/cpu_pkg.sv
// Shared CPU decode constants and jump-controller state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  localparam logic [4:0] LINK_REG   = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } jc_state_t;

endpackage

// File: rtl/jump_target.sv
// Combinational control-transfer decode: taken flag and target PC for the ID instruction.
module jump_target
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [ADDR_W-1:0] pc4,
  input  logic [15:0]       imm,
  input  logic [25:0]       jidx,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  output logic              taken,
  output logic [ADDR_W-1:0] target
);

  logic signed [31:0] boff;
  logic [31:0]        jtgt;
  logic [3:0]         region;

  // Region bits are taken from a 32-bit view so narrow PCs see zeros above ADDR_W.
  assign region = 4'(32'(pc4) >> 28);
  assign jtgt   = {region, jidx, 2'b00};
  assign boff   = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = '0;
    unique case (op)
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = ADDR_W'(jtgt);
      end
      OP_BEQ: begin
        taken  = (rs_val == rt_val);
        target = pc4 + ADDR_W'(boff);
      end
      OP_BNE: begin
        taken  = (rs_val != rt_val);
        target = pc4 + ADDR_W'(boff);
      end
      OP_SPECIAL: begin
        if (funct == FUNCT_JR || funct == FUNCT_JALR) begin
          taken  = 1'b1;
          target = ADDR_W'(rs_val);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jump_ctrl.sv
// ID-stage jump/branch redirect controller: IDLE -> REDIRECT (handshake) -> FLUSH.
// Optional link-register write enabled by defining JUMP_CTRL_LINK_EN.
module jump_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_funct,
  input  logic [ADDR_W-1:0] id_pc4,
  input  logic [15:0]       id_imm,
  input  logic [25:0]       id_jidx,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic              if_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              id_hold,
  output logic              jump,
  output logic              link_we,
  output logic [4:0]        link_addr,
  output logic [31:0]       link_data
);

  jc_state_t         state_q, state_d;
  logic [2:0]        cnt_q;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              accept;
  logic              handshake;

  jump_target #(.ADDR_W(ADDR_W)) u_target (
    .op     (id_op),
    .funct  (id_funct),
    .pc4    (id_pc4),
    .imm    (id_imm),
    .jidx   (id_jidx),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .taken  (taken),
    .target (target)
  );

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    handshake      = 1'b0;
    redirect_valid = 1'b0;
    flush_if       = 1'b0;
    id_hold        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (id_valid && taken) begin
          accept  = 1'b1;
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        id_hold        = 1'b1;
        if (if_ready) begin
          handshake = 1'b1;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_if = 1'b1;
        id_hold  = 1'b1;
        if (cnt_q <= 3'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      redirect_pc <= '0;
      jump        <= 1'b0;
    end else begin
      state_q <= state_d;
      jump    <= accept;
      if (accept) redirect_pc <= target;
      // Counter is loaded at the handshake so FLUSH lasts exactly FLUSH_CYCLES.
      if (handshake) cnt_q <= 3'(FLUSH_CYCLES);
      else if (state_q == ST_FLUSH) cnt_q <= cnt_q - 3'd1;
    end
  end

`ifdef JUMP_CTRL_LINK_EN
  logic              is_link;
  logic              link_d;
  logic [ADDR_W-1:0] ret_addr;

  assign is_link  = (id_op == OP_JAL) ||
                    (id_op == OP_SPECIAL && id_funct == FUNCT_JALR);
  assign link_d   = accept && is_link;
  assign ret_addr = id_pc4 + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      link_we   <= 1'b0;
      link_addr <= 5'd0;
      link_data <= 32'd0;
    end else begin
      link_we   <= link_d;
      link_addr <= link_d ? LINK_REG : 5'd0;
      link_data <= link_d ? 32'(ret_addr) : 32'd0;
    end
  end
`else
  assign link_we   = 1'b0;
  assign link_addr = 5'd0;
  assign link_data = 32'd0;
`endif

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: vector table with scoreboard plus multi-cycle sequences.
module tb_jump_ctrl;

  localparam int ADDR_W = 32;
  localparam int FLUSH  = 3;
`ifdef JUMP_CTRL_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_op, id_funct;
  logic [31:0] id_pc4;
  logic [15:0] id_imm;
  logic [25:0] id_jidx;
  logic [31:0] rs_val, rt_val;
  logic        if_ready;
  logic        redirect_valid, flush_if, id_hold, jump, link_we;
  logic [31:0] redirect_pc, link_data;
  logic [4:0]  link_addr;

  int total = 0;
  int passed = 0;

  jump_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_pc4(id_pc4), .id_imm(id_imm), .id_jidx(id_jidx), .rs_val(rs_val), .rt_val(rt_val),
    .if_ready(if_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .id_hold(id_hold), .jump(jump), .link_we(link_we),
    .link_addr(link_addr), .link_data(link_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        taken;
    logic [31:0] pc;
    logic        lnk;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    logic        lwe;
    logic [31:0] ldata;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    id_op    = v.op;
    id_funct = v.funct;
    id_pc4   = v.pc4;
    id_imm   = v.imm;
    id_jidx  = v.jidx;
    rs_val   = v.rs;
    rt_val   = v.rt;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rv"},    {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_hold"},  {31'd0, id_hold},        32'd0);
    chk({tag, "_flush"}, {31'd0, flush_if},       32'd0);
  endtask

  // Count flush cycles from the first FLUSH sample; the bound guards a stuck FSM.
  task automatic count_flush(input string tag);
    int n = 0;
    while (flush_if && n < 20) begin
      chk({tag, "_flush_hold"}, {31'd0, id_hold}, 32'd1);
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_flush_len"}, n, FLUSH);
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   nrv;
    logic [31:0] pc_hold;

    //           op        funct      pc4           imm      jidx         rs            rt        tk    pc            lnk
    vecs[0]  = '{6'b000010, 6'd0,      32'h00400004, 16'h0,   26'h0100010, 32'd0,        32'd0,    1'b1, 32'h00400040, 1'b0};
    vecs[1]  = '{6'b000100, 6'd0,      32'h00000100, 16'hFFFF, 26'd0,      32'd5,        32'd5,    1'b1, 32'h000000FC, 1'b0};
    vecs[2]  = '{6'b000101, 6'd0,      32'h00000100, 16'hFFFF, 26'd0,      32'd5,        32'd5,    1'b0, 32'h0,        1'b0};
    vecs[3]  = '{6'b000000, 6'b001000, 32'h00000010, 16'h0,   26'd0,       32'h1234,     32'd0,    1'b1, 32'h00001234, 1'b0};
    vecs[4]  = '{6'b000011, 6'd0,      32'h00000200, 16'h0,   26'h10,      32'd0,        32'd0,    1'b1, 32'h00000040, 1'b1};
    vecs[5]  = '{6'b000000, 6'b001001, 32'h00000300, 16'h0,   26'd0,       32'h80000000, 32'd0,    1'b1, 32'h80000000, 1'b1};
    vecs[6]  = '{6'b000100, 6'd0,      32'h00000100, 16'h4,   26'd0,       32'd1,        32'd2,    1'b0, 32'h0,        1'b0};
    vecs[7]  = '{6'b000101, 6'd0,      32'h00001000, 16'h0010, 26'd0,      32'd1,        32'd2,    1'b1, 32'h00001040, 1'b0};
    vecs[8]  = '{6'b000000, 6'b100000, 32'h00000100, 16'h0,   26'd0,       32'h5555,     32'd0,    1'b0, 32'h0,        1'b0};
    vecs[9]  = '{6'b000010, 6'd0,      32'hF0000000, 16'h0,   26'h3FFFFFF, 32'd0,        32'd0,    1'b1, 32'hFFFFFFFC, 1'b0};
    vecs[10] = '{6'b000100, 6'd0,      32'hFFFFFFF0, 16'h7FFF, 26'd0,      32'd0,        32'd0,    1'b1, 32'h0001FFEC, 1'b0};
    vecs[11] = '{6'b000110, 6'd0,      32'h00000100, 16'h1,   26'd0,       32'd0,        32'd0,    1'b0, 32'h0,        1'b0};

    rst = 1'b1; id_valid = 1'b0; if_ready = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_jump", {31'd0, jump}, 32'd0);
    chk("reset_pc", redirect_pc, 32'd0);
    chk("reset_lwe", {31'd0, link_we}, 32'd0);
    chk("reset_laddr", {27'd0, link_addr}, 32'd0);
    chk("reset_ldata", link_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v);
      id_valid = 1'b1;
      if_ready = 1'b0;
      e.taken = v.taken;
      e.pc    = v.pc;
      e.lwe   = LINK & v.taken & v.lnk;
      e.ldata = e.lwe ? v.pc4 + 32'd4 : 32'd0;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_jump", i), {31'd0, jump}, {31'd0, e.taken});
      chk($sformatf("v%0d_rv", i), {31'd0, redirect_valid}, {31'd0, e.taken});
      chk($sformatf("v%0d_lwe", i), {31'd0, link_we}, {31'd0, e.lwe});
      chk($sformatf("v%0d_laddr", i), {27'd0, link_addr}, e.lwe ? 32'd31 : 32'd0);
      chk($sformatf("v%0d_ldata", i), link_data, e.ldata);
      if (e.taken) chk($sformatf("v%0d_pc", i), redirect_pc, e.pc);
      @(negedge clk);
      id_valid = 1'b0;
      if (e.taken) begin
        if_ready = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d_jump_pulse", i), {31'd0, jump}, 32'd0);
        if_ready = 1'b0;
        count_flush($sformatf("v%0d", i));
      end else begin
        @(posedge clk); #1;
        check_idle_outputs($sformatf("v%0d_nt", i));
      end
    end

    // JR with IF stalling three cycles; ID keeps presenting a J that must be ignored.
    @(negedge clk);
    v = vecs[3];
    drive(v);
    id_valid = 1'b1;
    @(posedge clk); #1;
    chk("stall_jump", {31'd0, jump}, 32'd1);
    pc_hold = redirect_pc;
    chk("stall_pc", pc_hold, 32'h00001234);
    drive(vecs[0]);
    nrv = 0;
    for (int c = 0; c < 4; c++) begin
      if (redirect_valid && id_hold) nrv++;
      chk($sformatf("stall_pc_c%0d", c), redirect_pc, 32'h00001234);
      @(negedge clk);
      if (c == 3) if_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("stall_nojump_c%0d", c), {31'd0, jump}, 32'd0);
    end
    chk("stall_rv_cycles", nrv, 4);
    if_ready = 1'b0;
    id_valid = 1'b0;
    count_flush("stall");

    // Reset mid-REDIRECT abandons the redirect; a fresh J is then accepted.
    @(negedge clk);
    drive(vecs[0]);
    id_valid = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_rv", {31'd0, redirect_valid}, 32'd1);
    @(negedge clk);
    id_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("rstmid");
    chk("rstmid_pc", redirect_pc, 32'd0);
    chk("rstmid_jump", {31'd0, jump}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if_ready = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("rstmid_idle");
    @(negedge clk);
    id_valid = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_new_jump", {31'd0, jump}, 32'd1);
    chk("rstmid_new_pc", redirect_pc, 32'h00400040);
    @(negedge clk);
    id_valid = 1'b0;
    @(posedge clk); #1;
    count_flush("rstmid_new");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
